// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, unsigned or two's-complement
// binary in, sign flag plus BCD digits out after WIDTH iterations.
module bin2bcd_seq #(
    parameter int WIDTH = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      din,
    input  logic                  is_signed,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    if (10 ** DIGITS <= 2 ** WIDTH - 1) begin : g_range_check
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end
    typedef enum logic {IDLE, CONV} state_t;
    state_t r_state, w_state_nx;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_mag, w_mag_nx;
    logic [4*DIGITS-1:0] r_scr, w_adj, w_scr_nx, r_bcd;
    logic                r_sign, r_neg, r_done;
    logic                w_cap, w_last, w_sign;
    assign w_cap  = r_state == IDLE && start;
    assign w_last = r_cnt == LAST;
    assign w_sign = is_signed & din[WIDTH-1];
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        assign w_adj[4*i+:4] = r_scr[4*i+:4] >= 4'd5 ? r_scr[4*i+:4] + 4'd3 : r_scr[4*i+:4];
    end
    // The bit shifted out of the top digit is always zero for a valid DIGITS.
    assign {w_scr_nx, w_mag_nx} = {w_adj, r_mag} << 1;
    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE) w_state_nx = start ? CONV : IDLE;
        else                 w_state_nx = w_last ? IDLE : CONV;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_mag  <= '0;
            r_scr  <= '0;
            r_sign <= 1'b0;
            r_bcd  <= '0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cap) begin
                r_sign <= w_sign;
                r_mag  <= w_sign ? ~din + 1'b1 : din;
                r_scr  <= '0;
                r_cnt  <= '0;
            end else if (r_state == CONV) begin
                r_scr <= w_scr_nx;
                r_mag <= w_mag_nx;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_bcd  <= w_scr_nx;
                    r_neg  <= r_sign;
                    r_done <= 1'b1;
                end
            end
        end
    end
    assign busy = r_state == CONV;
    assign done = r_done;
    assign neg  = r_neg;
    assign bcd  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: table vectors, hand-written corner sequences and a shuffled
// exhaustive sweep checked against a decimal reference model.
module tb_bin2bcd_seq;
    logic        clk = 1'b0;
    logic        rst, start, is_signed, busy, done, neg;
    logic [9:0]  din;
    logic [15:0] bcd;
    int n_vec = 0;
    int n_err = 0;

    bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .is_signed(is_signed),
        .busy(busy), .done(done), .neg(neg), .bcd(bcd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  d;
        logic        s;
        logic [15:0] b;
        logic        n;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [9:0] d, input logic s,
                                  output logic [15:0] b, output logic n);
        int v, m, p;
        v = (s && d >= 10'd512) ? int'(d) - 1024 : int'(d);
        n = v < 0;
        m = n ? -v : v;
        b = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            b[4*k+:4] = 4'((m / p) % 10);
            p = p * 10;
        end
    endfunction

    task automatic convert(input logic [9:0] d, input logic s, output int lat);
        @(negedge clk);
        start = 1'b1; din = d; is_signed = s;
        @(negedge clk);
        start = 1'b0; din = 10'($urandom); is_signed = 1'($urandom);
        lat = 0;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string nm, input logic [9:0] d, input logic s,
                             input logic [15:0] eb, input logic en);
        int lat;
        convert(d, s, lat);
        chk({nm, " latency"}, lat, 10);
        chk({nm, " bcd"}, bcd, eb);
        chk({nm, " neg"}, neg, en);
        @(negedge clk);
        chk({nm, " done pulse"}, done, 0);
    endtask

    initial begin
        vec_t tbl[10];
        logic [15:0] eb;
        logic en;
        int busy_cnt, done_cnt, d1, d2, unstable;
        logic [15:0] b1, b2;
        int off;
        tbl = '{
            '{10'h3FF, 1'b0, 16'h1023, 1'b0},
            '{10'h200, 1'b1, 16'h0512, 1'b1},
            '{10'h3FF, 1'b1, 16'h0001, 1'b1},
            '{10'h1FF, 1'b1, 16'h0511, 1'b0},
            '{10'd0,   1'b1, 16'h0000, 1'b0},
            '{10'd0,   1'b0, 16'h0000, 1'b0},
            '{10'd9,   1'b0, 16'h0009, 1'b0},
            '{10'd10,  1'b0, 16'h0010, 1'b0},
            '{10'h200, 1'b0, 16'h0512, 1'b0},
            '{10'd999, 1'b0, 16'h0999, 1'b0}
        };
        rst = 1'b1; start = 1'b1; din = 10'h3FF; is_signed = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset neg", neg, 0);
        chk("reset bcd", bcd, 0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("table[%0d]", i), tbl[i].d, tbl[i].s, tbl[i].b, tbl[i].n);

        // busy guard: second start during conversion must be ignored
        @(negedge clk);
        start = 1'b1; din = 10'd7; is_signed = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            start = (i == 2);
            if (i == 2) din = 10'd999;
        end
        chk("guard busy cycles", busy_cnt, 10);
        chk("guard done count", done_cnt, 1);
        chk("guard bcd", bcd, 16'h0007);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; din = 10'd100; is_signed = 1'b0;
        d1 = -1; d2 = -1; unstable = 0; b1 = '0; b2 = '0;
        for (int i = 0; i < 40 && d2 < 0; i++) begin
            @(negedge clk);
            if (i == 0) din = 10'd250;
            if (d1 >= 0 && !done && bcd !== 16'h0100) unstable++;
            if (done && d1 < 0) begin d1 = i; b1 = bcd; end
            else if (done) begin d2 = i; b2 = bcd; start = 1'b0; end
        end
        start = 1'b0;
        chk("b2b spacing", d2 - d1, 11);
        chk("b2b first bcd", b1, 16'h0100);
        chk("b2b second bcd", b2, 16'h0250);
        chk("b2b bcd stable", unstable, 0);
        repeat (2) @(negedge clk);

        // reset mid-conversion aborts with no done
        start = 1'b1; din = 10'd345; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort bcd", bcd, 0);
        chk("abort neg", neg, 0);
        done_cnt = 0;
        repeat (14) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        chk("abort no done", done_cnt, 0);
        run_check("after abort zero", 10'd0, 1'b1, 16'h0000, 1'b0);

        // shuffled exhaustive sweep with random idle gaps
        off = int'($urandom_range(0, 2047));
        for (int i = 0; i < 2048; i++) begin
            int v, lat;
            v = (i + off) % 2048;
            model(10'(v), 1'(v >> 10), eb, en);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            convert(10'(v), 1'(v >> 10), lat);
            chk($sformatf("sweep %0d latency", v), lat, 10);
            chk($sformatf("sweep %0d bcd", v), bcd, eb);
            chk($sformatf("sweep %0d neg", v), neg, en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
